// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder with programmable wait states and saturating debug counters
module dmem_responder #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  ld_cnt,
    output logic [CNT_W-1:0]  st_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic we_q, we_d, ready_q, ready_d, valid_q, valid_d, err_q, err_d;
    logic mem_we, in_range;
    logic [31:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0] ld_q, ld_d, st_q, st_d, ec_q, ec_d;
    logic [DATA_W-1:0] mem [DEPTH];
    assign in_range  = addr_q < 32'(DEPTH);
    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ld_cnt    = ld_q;
    assign st_cnt    = st_q;
    assign err_cnt   = ec_q;
    // Next-state logic: capture in IDLE, count down in WAIT, access once, then hold the response until accepted
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ld_d    = ld_q;
        st_d    = st_q;
        ec_d    = ec_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: if (ready_q && req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                wait_d  = 4'(WAIT_CYC);
                state_d = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                wait_d  = wait_q - 4'd1;
                state_d = (wait_q == 4'd1) ? S_ACCESS : S_WAIT;
            end
            S_ACCESS: begin
                mem_we  = in_range && we_q;
                valid_d = 1'b1;
                err_d   = !in_range;
                rdata_d = !in_range ? '0 : we_q ? wdata_q : mem[addr_q[AW-1:0]];
                ec_d    = !in_range ? ec_q + CNT_W'(~&ec_q) : ec_q;
                st_d    = (in_range && we_q) ? st_q + CNT_W'(~&st_q) : st_q;
                ld_d    = (in_range && !we_q) ? ld_q + CNT_W'(~&ld_q) : ld_q;
                state_d = S_RESP;
            end
            S_RESP: if (rsp_ready) begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        ready_d = state_d == S_IDLE;
    end
    // Control, response and counter registers; an asynchronous reset drops any in-flight request
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ld_q    <= '0;
            st_q    <= '0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            ec_q    <= ec_d;
        end
    end
    // Storage array, written only during an in-range store access and never reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
    end
endmodule
